key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue.sv | 85 ++++++++
 tb/tb_key_event_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// Key event queue: scans debounced key levels one index per cycle and turns
// level changes into press/release events held in a first-word-fall-through FIFO.
module key_event_queue #(
  parameter int KEYS  = 61,
  parameter int DEPTH = 16,
  localparam int CODE_W = $clog2(KEYS),
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS-1:0]   keys_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CODE_W-1:0] evt_code_o,
  output logic              evt_press_o,
  output logic [CNT_W-1:0]  fifo_count_o,
  output logic              pending_o
);

  logic [KEYS-1:0]   tracked_reg, tracked_next;
  logic [CODE_W-1:0] scan_reg, scan_next;
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CODE_W:0]   mem [DEPTH];

  logic key_level;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign key_level  = keys_i[scan_reg];
  assign fifo_full  = (count_reg == CNT_W'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = (key_level != tracked_reg[scan_reg]) && !fifo_full;
  assign pop        = !fifo_empty && evt_ready_i;

  generate
    for (genvar gi = 0; gi < KEYS; gi++) begin : g_track
      assign tracked_next[gi] = (push && (scan_reg == CODE_W'(gi))) ? keys_i[gi]
                                                                   : tracked_reg[gi];
    end
  endgenerate

  always_comb begin
    scan_next  = (scan_reg == CODE_W'(KEYS - 1)) ? '0 : scan_reg + CODE_W'(1);
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tracked_reg <= keys_i;
      scan_reg    <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      tracked_reg <= tracked_next;
      scan_reg    <= scan_next;
      count_reg   <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
    end
  end

  // Storage is left uncleared on reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr_reg] <= {scan_reg, key_level};
    end
  end

  // Asynchronous read of the head entry gives first-word-fall-through behaviour.
  assign {evt_code_o, evt_press_o} = mem[rd_ptr_reg];
  assign evt_valid_o  = !fifo_empty;
  assign fifo_count_o = count_reg;
  assign pending_o    = |(keys_i ^ tracked_reg);

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: a cycle model feeds an expected-event
// queue that is compared against every handshake the DUT completes.
module tb_key_event_queue;

  localparam int KEYS   = 61;
  localparam int DEPTH  = 16;
  localparam int CODE_W = 6;
  localparam int CNT_W  = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [KEYS-1:0]   keys_i;
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [CODE_W-1:0] evt_code_o;
  logic              evt_press_o;
  logic [CNT_W-1:0]  fifo_count_o;
  logic              pending_o;

  key_event_queue #(.KEYS(KEYS), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .keys_i       (keys_i),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_code_o   (evt_code_o),
    .evt_press_o  (evt_press_o),
    .fifo_count_o (fifo_count_o),
    .pending_o    (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [KEYS-1:0]   m_tracked;
  int                m_scan;
  int                m_count;
  logic [CODE_W:0]   exp_q[$];

  // Observed drain statistics
  logic [KEYS-1:0]   pop_mask;
  int                pop_cnt;
  int                dup_cnt;
  logic [CODE_W:0]   last_pop;

  // One clock cycle: score any pop, advance the model across the edge, check state.
  task automatic step();
    logic          push;
    logic          pop;
    logic [CODE_W:0] exp;
    push = !rst_i && (keys_i[m_scan] != m_tracked[m_scan]) && (m_count != DEPTH);
    pop  = !rst_i && (m_count != 0) && evt_ready_i;
    if (pop) begin
      exp = exp_q.pop_front();
      checks++;
      if ({evt_valid_o, evt_code_o, evt_press_o} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL pop_data: got valid=%0b code=%0d press=%0b, expected valid=1 code=%0d press=%0b",
                 evt_valid_o, evt_code_o, evt_press_o, exp[CODE_W:1], exp[0]);
      end
      if (pop_mask[evt_code_o]) dup_cnt++;
      pop_mask[evt_code_o] = 1'b1;
      pop_cnt++;
      last_pop = {evt_code_o, evt_press_o};
    end
    @(posedge clk_i);
    if (rst_i) begin
      m_tracked = keys_i;
      m_scan    = 0;
      m_count   = 0;
      exp_q.delete();
    end else begin
      if (push) begin
        exp_q.push_back({CODE_W'(m_scan), keys_i[m_scan]});
        m_tracked[m_scan] = keys_i[m_scan];
      end
      m_count = m_count + int'(push) - int'(pop);
      m_scan  = (m_scan == KEYS - 1) ? 0 : m_scan + 1;
    end
    #1;
    checks++;
    if (fifo_count_o !== CNT_W'(m_count)) begin
      errors++;
      $display("FAIL count: got %0d, expected %0d", fifo_count_o, m_count);
    end
    checks++;
    if (evt_valid_o !== (m_count != 0)) begin
      errors++;
      $display("FAIL valid: got %0b, expected %0b", evt_valid_o, (m_count != 0));
    end
    checks++;
    if (pending_o !== (|(keys_i ^ m_tracked))) begin
      errors++;
      $display("FAIL pending: got %0b, expected %0b", pending_o, |(keys_i ^ m_tracked));
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    keys_i      = '0;
    evt_ready_i = 1'b0;
    do_reset();
    #1;
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, expected 0", evt_valid_o); end
    checks++;
    if (fifo_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", fifo_count_o); end
    checks++;
    if (pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b, expected 0", pending_o); end
  endtask

  task automatic test_single_press();
    int n;
    int exp_n;
    bit found;
    exp_n = ((5 - m_scan + KEYS) % KEYS) + 1;
    keys_i[5] = 1'b1;
    #1;
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("FAIL press_pending: got %0b, expected 1", pending_o); end
    n = 0;
    found = 0;
    while (!found && n < KEYS + 1) begin
      step();
      n++;
      if (evt_valid_o === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != exp_n) begin
      errors++;
      $display("FAIL press_latency: got %0d edges (found=%0b), expected %0d", n, found, exp_n);
    end
    checks++;
    if ({evt_code_o, evt_press_o} !== {6'd5, 1'b1}) begin
      errors++;
      $display("FAIL press_event: got code=%0d press=%0b, expected code=5 press=1", evt_code_o, evt_press_o);
    end
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    repeat (KEYS) step();
    checks++;
    if (fifo_count_o !== '0) begin errors++; $display("FAIL press_single: got count %0d, expected 0", fifo_count_o); end
  endtask

  task automatic test_overflow();
    int n;
    int max_cnt;
    logic [KEYS-1:0] exp_mask;
    pop_mask    = '0;
    pop_cnt     = 0;
    dup_cnt     = 0;
    exp_mask    = '0;
    max_cnt     = 0;
    evt_ready_i = 1'b0;
    for (int i = 20; i < 40; i++) begin
      keys_i[i]   = 1'b1;
      exp_mask[i] = 1'b1;
    end
    repeat (2 * KEYS) begin
      step();
      if (int'(fifo_count_o) > max_cnt) max_cnt = int'(fifo_count_o);
    end
    checks++;
    if (fifo_count_o !== CNT_W'(DEPTH) || max_cnt != DEPTH) begin
      errors++;
      $display("FAIL ovf_saturate: got count %0d max %0d, expected %0d", fifo_count_o, max_cnt, DEPTH);
    end
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("FAIL ovf_pending: got %0b, expected 1", pending_o); end
    evt_ready_i = 1'b1;
    n = 0;
    while ((evt_valid_o || pending_o) && n < 4 * KEYS) begin
      step();
      n++;
    end
    evt_ready_i = 1'b0;
    checks++;
    if (evt_valid_o || pending_o) begin
      errors++;
      $display("FAIL ovf_drain_timeout: got valid=%0b pending=%0b, expected both 0", evt_valid_o, pending_o);
    end
    checks++;
    if (pop_cnt != 20 || dup_cnt != 0 || pop_mask !== exp_mask) begin
      errors++;
      $display("FAIL ovf_drained: got %0d events %0d dups mask %h, expected 20 events 0 dups mask %h",
               pop_cnt, dup_cnt, pop_mask, exp_mask);
    end
  endtask

  task automatic test_held_through_reset();
    int n;
    bit found;
    keys_i     = '0;
    keys_i[60] = 1'b1;
    do_reset();
    repeat (KEYS + 1) step();
    checks++;
    if (fifo_count_o !== '0) begin errors++; $display("FAIL held_no_press: got count %0d, expected 0", fifo_count_o); end
    keys_i[60] = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < KEYS + 1) begin
      step();
      n++;
      if (evt_valid_o === 1'b1) found = 1;
    end
    checks++;
    if (!found || {evt_code_o, evt_press_o} !== {6'd60, 1'b0}) begin
      errors++;
      $display("FAIL held_release: got found=%0b code=%0d press=%0b, expected code=60 press=0",
               found, evt_code_o, evt_press_o);
    end
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    repeat (KEYS) step();
    checks++;
    if (fifo_count_o !== '0) begin errors++; $display("FAIL held_single: got count %0d, expected 0", fifo_count_o); end
  endtask

  task automatic test_full_pop_same_cycle();
    int n;
    evt_ready_i = 1'b0;
    for (int i = 20; i < 36; i++) keys_i[i] = 1'b1;
    n = 0;
    while (fifo_count_o != CNT_W'(DEPTH) && n < 2 * KEYS) begin
      step();
      n++;
    end
    checks++;
    if (fifo_count_o !== CNT_W'(DEPTH)) begin errors++; $display("FAIL full_fill: got %0d, expected %0d", fifo_count_o, DEPTH); end
    while (m_scan != 10) step();
    keys_i[10]  = 1'b1;
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    checks++;
    if (fifo_count_o !== CNT_W'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_no_push: got count %0d, expected %0d", fifo_count_o, DEPTH - 1);
    end
    repeat (KEYS - 1) step();
    checks++;
    if (fifo_count_o !== CNT_W'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_wait_slot: got count %0d, expected %0d", fifo_count_o, DEPTH - 1);
    end
    step();
    checks++;
    if (fifo_count_o !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL full_next_pass: got count %0d, expected %0d", fifo_count_o, DEPTH);
    end
    evt_ready_i = 1'b1;
    n = 0;
    while (evt_valid_o && n < 4 * DEPTH) begin
      step();
      n++;
    end
    evt_ready_i = 1'b0;
    checks++;
    if (last_pop !== {6'd10, 1'b1} || evt_valid_o) begin
      errors++;
      $display("FAIL full_last_event: got code=%0d press=%0b valid=%0b, expected code=10 press=1 valid=0",
               last_pop[CODE_W:1], last_pop[0], evt_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    evt_ready_i = 1'b0;
    for (int i = 40; i < 47; i++) keys_i[i] = 1'b1;
    n = 0;
    while (fifo_count_o != 7 && n < 2 * KEYS) begin
      step();
      n++;
    end
    checks++;
    if (fifo_count_o !== 5'd7) begin errors++; $display("FAIL mid_fill: got %0d, expected 7", fifo_count_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (evt_valid_o !== 1'b0 || fifo_count_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b count=%0d, expected valid=0 count=0", evt_valid_o, fifo_count_o);
    end
    step();
  endtask

  task automatic test_glitch();
    while (m_scan != 40) step();
    keys_i[3] = 1'b1;
    #1;
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("FAIL glitch_pending: got %0b, expected 1", pending_o); end
    step();
    keys_i[3] = 1'b0;
    repeat (KEYS) step();
    checks++;
    if (fifo_count_o !== '0 || pending_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_event: got count=%0d pending=%0b, expected 0 and 0", fifo_count_o, pending_o);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int n;
    repeat (600) begin
      if ($urandom_range(3, 0) == 0) begin
        idx = $urandom_range(KEYS - 1, 0);
        keys_i[idx] = ~keys_i[idx];
      end
      evt_ready_i = ($urandom_range(3, 0) != 0);
      step();
    end
    evt_ready_i = 1'b1;
    n = 0;
    while ((evt_valid_o || pending_o) && n < 8 * KEYS) begin
      step();
      n++;
    end
    evt_ready_i = 1'b0;
    checks++;
    if (evt_valid_o || pending_o || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%0b pending=%0b left=%0d, expected all 0",
               evt_valid_o, pending_o, exp_q.size());
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    keys_i      = '0;
    evt_ready_i = 1'b0;
    m_tracked   = '0;
    m_scan      = 0;
    m_count     = 0;
    pop_mask    = '0;
    pop_cnt     = 0;
    dup_cnt     = 0;
    last_pop    = '0;
    test_reset();
    test_single_press();
    test_overflow();
    test_held_through_reset();
    test_full_pop_same_cycle();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
